multi_cycle_ctrl: RTL and testbench



---
 rtl/multi_cycle_pkg.sv | 32 +++
 rtl/multi_cycle_ctrl_if.sv | 40 ++++
 rtl/wait_watchdog.sv | 42 ++++
 rtl/multi_cycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multicycle RV32I control sequencer.
// Contents: state encodings (exported on the debug state/nextState ports),
// RV32I major opcode constants, and an opcode legality helper.
package multi_cycle_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // True for every opcode this core decodes, SYSTEM included.
    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_R, OP_IALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                          OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM};
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between decode/memory and the control sequencer.
// master: the sequencer (consumes op and ready strobes, drives enables,
//         status flags, counters and debug state).
// slave : the surrounding datapath / memory side.
interface multi_cycle_ctrl_if #(
    parameter int unsigned OP_W    = 7,
    parameter int unsigned STATE_W = 3,
    parameter int unsigned CNT_W   = 32
) ();

    logic [OP_W-1:0]    op;
    logic               imem_ready;
    logic               dmem_ready;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] nextState;
    logic               imem_req;
    logic               IRWre;
    logic               PCWre;
    logic               RegWre;
    logic               mem_rd;
    logic               mem_wr;
    logic               halted;
    logic               illegal;
    logic               bus_err;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   instret;

    modport master (
        input  op, imem_ready, dmem_ready,
        output state, nextState, imem_req, IRWre, PCWre, RegWre, mem_rd, mem_wr,
               halted, illegal, bus_err, cycle_cnt, instret
    );

    modport slave (
        output op, imem_ready, dmem_ready,
        input  state, nextState, imem_req, IRWre, PCWre, RegWre, mem_rd, mem_wr,
               halted, illegal, bus_err, cycle_cnt, instret
    );

endinterface

// File: rtl/wait_watchdog.sv
// Memory wait watchdog.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   en_i      - controller is in a state that waits on a ready strobe
//   ready_i   - the awaited ready strobe
//   clr_i     - controller changes state this cycle
//   timeout_o - MAX_WAIT waiting cycles already elapsed and ready is still low
module wait_watchdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic ready_i,
    input  logic clr_i,
    output logic timeout_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !ready_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready seen while the count sits at MAX_WAIT still wins.
    assign timeout_o = en_i && !ready_i && (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Control sequencer for the multicycle RV32I core.
// Ports:
//   CLK   - clock, rising edge
//   Reset - synchronous active-high reset, overrides every other event
//   bus   - master side of multi_cycle_ctrl_if: op, imem_ready, dmem_ready in;
//           state/nextState debug, datapath enables (imem_req, IRWre, PCWre,
//           RegWre, mem_rd, mem_wr), sticky halted/illegal/bus_err flags and
//           cycle_cnt/instret performance counters out.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter int unsigned OP_W     = 7,
    parameter int unsigned STATE_W  = 3,   // must be >= 3
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 15   // 1 .. 255
) (
    input  logic               CLK,
    input  logic               Reset,
    multi_cycle_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic [OP_W-1:0]  op_raw;
    logic [6:0]       op7;
    logic             is_load, is_store, is_branch;

    logic imem_req, ir_we, pc_we, reg_we, mem_rd, mem_wr;
    logic retire, set_illegal, set_bus_err;
    logic wd_en, wd_ready, timeout;

    assign op_raw    = bus.op;
    assign op7       = op_raw[6:0];
    assign is_load   = (op7 == OP_LOAD);
    assign is_store  = (op7 == OP_STORE);
    assign is_branch = (op7 == OP_BRANCH);

    // Only IF and MEM wait on a ready strobe.
    assign wd_en    = (state_q == S_IF) || (state_q == S_MEM);
    assign wd_ready = (state_q == S_IF) ? bus.imem_ready : bus.dmem_ready;

    wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_watchdog (
        .clk_i     (CLK),
        .rst_i     (Reset),
        .en_i      (wd_en),
        .ready_i   (wd_ready),
        .clr_i     (state_d != state_q),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        unique case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_ID: begin
                if (op7 == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else if (is_legal_op(op7)) begin
                    state_d = S_EXE;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_EXE: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_rd = is_load;
                mem_wr = is_store;
                if (bus.dmem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_comb begin
        halted_d  = halted_q | (state_d == S_HALT);
        illegal_d = illegal_q | set_illegal;
        bus_err_d = bus_err_q | set_bus_err;
        // The cycle that enters HALT is still counted; HALT cycles are not.
        cyc_d     = (state_q != S_HALT) ? cyc_q + CNT_W'(1) : cyc_q;
        ret_d     = retire ? ret_q + CNT_W'(1) : ret_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IF;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cyc_q     <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
        end
    end

    assign bus.state     = STATE_W'(state_q);
    assign bus.nextState = STATE_W'(state_d);
    assign bus.imem_req  = imem_req;
    assign bus.IRWre     = ir_we;
    assign bus.PCWre     = pc_we;
    assign bus.RegWre    = reg_we;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.cycle_cnt = cyc_q;
    assign bus.instret   = ret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl. Each instruction's per-cycle stimulus and the
// outputs expected in that cycle are queued together; the run loop drives one
// stimulus entry per clock and compares the DUT against the matching entry.
module tb_multi_cycle_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EXE  = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    // Enable bit positions: imem_req, IRWre, PCWre, RegWre, mem_rd, mem_wr.
    localparam logic [5:0] EN_IMREQ = 6'b100000;
    localparam logic [5:0] EN_IRW   = 6'b010000;
    localparam logic [5:0] EN_PCW   = 6'b001000;
    localparam logic [5:0] EN_REGW  = 6'b000100;
    localparam logic [5:0] EN_MRD   = 6'b000010;
    localparam logic [5:0] EN_MWR   = 6'b000001;

    logic CLK = 1'b0;
    logic Reset;

    multi_cycle_ctrl_if #(.OP_W(7), .STATE_W(3), .CNT_W(32)) bus_if ();

    multi_cycle_ctrl #(
        .OP_W     (7),
        .STATE_W  (3),
        .CNT_W    (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus_if)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic       ir;
        logic       dr;
    } stim_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  en;
        logic        hlt;
        logic        ill;
        logic        berr;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int unsigned m_cyc;
    int unsigned m_ret;
    bit          m_ill;
    bit          m_berr;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc_no = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL cycle %0d %s: got %0h, want %0h", cyc_no, tag, obs, exp);
        end
    endtask

    task automatic push_cycle(input bit rst, input logic [2:0] st, input logic [6:0] o,
                              input bit ir, input bit dr, input logic [5:0] en,
                              input bit retire);
        stim_t s;
        exp_t  e;
        s.rst  = rst;
        s.op   = o;
        s.ir   = ir;
        s.dr   = dr;
        e.st   = st;
        e.en   = en;
        e.hlt  = (st == ST_HALT);
        e.ill  = m_ill;
        e.berr = m_berr;
        e.cyc  = m_cyc;
        e.ret  = m_ret;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (rst) begin
            m_cyc  = 0;
            m_ret  = 0;
            m_ill  = 0;
            m_berr = 0;
        end else begin
            if (st != ST_HALT) m_cyc++;
            if (retire) m_ret++;
        end
    endtask

    // One instruction: iw/dw are no-ready cycles before the imem/dmem ready;
    // rst_mem >= 0 asserts Reset in that MEM cycle and abandons the instruction.
    task automatic push_instr(input logic [6:0] o, input int iw, input int dw,
                              input int rst_mem);
        bit         rdy;
        bit         ld, st, br, to_exe;
        logic [5:0] en;
        ld     = (o == OPC_LOAD);
        st     = (o == OPC_STORE);
        br     = (o == OPC_BRANCH);
        to_exe = o inside {OPC_R, OPC_IALU, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                           OPC_LOAD, OPC_STORE, OPC_BRANCH};
        for (int k = 0; k <= iw; k++) begin
            rdy = (k == iw);
            push_cycle(1'b0, ST_IF, o, rdy, 1'b0, rdy ? (EN_IMREQ | EN_IRW) : EN_IMREQ, 1'b0);
            if (!rdy && k == int'(MAX_WAIT)) begin
                m_berr = 1;
                return;
            end
        end
        push_cycle(1'b0, ST_ID, o, 1'b0, 1'b0, 6'b0, 1'b0);
        if (!to_exe) begin
            if (o != OPC_SYSTEM) m_ill = 1;
            return;
        end
        push_cycle(1'b0, ST_EXE, o, 1'b0, 1'b0, br ? EN_PCW : 6'b0, br);
        if (br) return;
        if (ld || st) begin
            for (int k = 0; k <= dw; k++) begin
                rdy = (k == dw);
                en  = ld ? EN_MRD : EN_MWR;
                if (st && rdy) en = en | EN_PCW;
                push_cycle(k == rst_mem, ST_MEM, o, 1'b0, rdy, en, st && rdy);
                if (k == rst_mem) return;
                if (!rdy && k == int'(MAX_WAIT)) begin
                    m_berr = 1;
                    return;
                end
            end
            if (st) return;
        end
        push_cycle(1'b0, ST_WB, o, 1'b0, 1'b0, EN_REGW | EN_PCW, 1'b1);
    endtask

    // n cycles parked in HALT; Reset is asserted during the last one.
    task automatic push_halt(input int n, input logic [6:0] o);
        for (int i = 0; i < n; i++) begin
            push_cycle(i == n - 1, ST_HALT, o, 1'b1, 1'b1, 6'b0, 1'b0);
        end
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        Reset              = 1'b1;
        bus_if.op          = '0;
        bus_if.imem_ready  = 1'b1;
        bus_if.dmem_ready  = 1'b0;
        m_cyc  = 0;
        m_ret  = 0;
        m_ill  = 0;
        m_berr = 0;

        push_instr(OPC_R,      0,  0, -1);
        push_instr(OPC_LOAD,   0,  3, -1);
        push_instr(OPC_BRANCH, 0,  0, -1);
        push_instr(OPC_STORE,  0,  0, -1);
        push_instr(OPC_IALU,   2,  0, -1);
        push_instr(OPC_LUI,    0,  0, -1);
        push_instr(OPC_AUIPC,  0,  0, -1);
        push_instr(OPC_JAL,    0,  0, -1);
        push_instr(OPC_JALR,   0,  0, -1);
        push_instr(OPC_STORE,  1,  2, -1);
        push_instr(OPC_LOAD,   0, 15, -1);   // ready exactly at the limit
        push_instr(OPC_R,     15,  0, -1);   // ready exactly at the limit
        push_instr(OPC_LOAD,   0, 20, -1);   // data-side timeout
        push_halt(4, OPC_LOAD);
        push_instr(OPC_SYSTEM, 0,  0, -1);
        push_halt(5, OPC_SYSTEM);
        push_instr(OPC_BAD,    0,  0, -1);
        push_halt(10, OPC_BAD);
        push_instr(OPC_R,     20,  0, -1);   // fetch-side timeout
        push_halt(3, OPC_R);
        push_instr(OPC_LOAD,   0, 20,  5);   // reset mid-wait
        push_instr(OPC_R,      0,  0, -1);
        push_instr(OPC_STORE,  0,  0, -1);

        @(posedge CLK);
        #1;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            Reset             = s.rst;
            bus_if.op         = s.op;
            bus_if.imem_ready = s.ir;
            bus_if.dmem_ready = s.dr;
            @(negedge CLK);
            e = exp_q.pop_front();
            check_val("state",     32'(bus_if.state),     32'(e.st));
            check_val("imem_req",  32'(bus_if.imem_req),  32'(e.en[5]));
            check_val("IRWre",     32'(bus_if.IRWre),     32'(e.en[4]));
            check_val("PCWre",     32'(bus_if.PCWre),     32'(e.en[3]));
            check_val("RegWre",    32'(bus_if.RegWre),    32'(e.en[2]));
            check_val("mem_rd",    32'(bus_if.mem_rd),    32'(e.en[1]));
            check_val("mem_wr",    32'(bus_if.mem_wr),    32'(e.en[0]));
            check_val("halted",    32'(bus_if.halted),    32'(e.hlt));
            check_val("illegal",   32'(bus_if.illegal),   32'(e.ill));
            check_val("bus_err",   32'(bus_if.bus_err),   32'(e.berr));
            check_val("cycle_cnt", bus_if.cycle_cnt,      e.cyc);
            check_val("instret",   bus_if.instret,        e.ret);
            cyc_no++;
            @(posedge CLK);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
